// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: NUM_PORTS masters share one slave, one tenure at a time.
// Optional stalled-strobe timeout is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arb #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    m_cyc,
  input  logic [NUM_PORTS-1:0]    m_stb,
  input  logic [NUM_PORTS-1:0]    m_we,
  input  logic [4*NUM_PORTS-1:0]  m_sel,
  input  logic [32*NUM_PORTS-1:0] m_adr,
  input  logic [32*NUM_PORTS-1:0] m_datw,
  output logic [NUM_PORTS-1:0]    m_ack,
  output logic [NUM_PORTS-1:0]    m_err,
  output logic [31:0]             m_datr,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [3:0]              wb_sel,
  output logic [31:0]             wb_adr,
  output logic [31:0]             wb_datw,
  input  logic                    wb_ack,
  input  logic [31:0]             wb_datr,
  output logic [NUM_PORTS-1:0]    grant
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("wb_rr_arb: NUM_PORTS or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  logic             busy;
  logic             own_cyc;
  logic             own_stb;
  logic             timeout_hit;

  assign busy    = (state == BUSY);
  assign own_cyc = m_cyc[owner];
  assign own_stb = m_stb[owner];

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall_cnt;

  assign timeout_hit = busy && (stall_cnt == TIMEOUT_LIMIT);

  // Counts only cycles where the slave sees a live strobe without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!busy || !own_cyc || wb_ack || timeout_hit) begin
      stall_cnt <= '0;
    end else if (own_stb) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign m_err = timeout_hit ? grant : '0;
`else
  assign timeout_hit = 1'b0;
  assign m_err       = '0;
`endif

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!pick_valid && m_cyc[(int'(last) + k) % NUM_PORTS]) begin
        pick_valid = 1'b1;
        pick       = IDX_W'((int'(last) + k) % NUM_PORTS);
      end
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = BUSY;
          owner_nxt = pick;
        end
      end
      BUSY: begin
        if (!own_cyc || timeout_hit) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    grant = '0;
    if (busy) grant[owner] = 1'b1;
  end

  assign m_ack   = wb_ack ? grant : '0;
  assign m_datr  = wb_datr;

  assign wb_cyc  = busy && own_cyc && !timeout_hit;
  assign wb_stb  = busy && own_stb && !timeout_hit;
  assign wb_we   = busy && m_we[owner];
  assign wb_sel  = busy ? m_sel[int'(owner)*4 +: 4]    : '0;
  assign wb_adr  = busy ? m_adr[int'(owner)*32 +: 32]  : '0;
  assign wb_datw = busy ? m_datw[int'(owner)*32 +: 32] : '0;

endmodule

// File: tb/tb_wb_rr_arb.sv
// Bench for wb_rr_arb: directed scenarios plus randomized traffic against a per-cycle
// behavioural model of ownership, rotation and (when compiled in) the stall timeout.
module tb_wb_rr_arb;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [4*N-1:0]  m_sel;
  logic [32*N-1:0] m_adr, m_datw;
  logic [N-1:0]    m_ack, m_err;
  logic [31:0]     m_datr;
  logic            wb_cyc, wb_stb, wb_we;
  logic [3:0]      wb_sel;
  logic [31:0]     wb_adr, wb_datw;
  logic            wb_ack;
  logic [31:0]     wb_datr;
  logic [N-1:0]    grant;

  wb_rr_arb #(.NUM_PORTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_datw(m_datw),
    .m_ack(m_ack), .m_err(m_err), .m_datr(m_datr),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_datw(wb_datw),
    .wb_ack(wb_ack), .wb_datr(wb_datr),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] drv_cyc, drv_stb;
  logic         drv_ack;

  // Reference model: owner index (-1 when idle), last owner, stalled-strobe count.
  int mdl_owner, mdl_last, mdl_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = N - 1;
    mdl_stall = 0;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    drv_cyc = '0;
    drv_stb = '0;
    drv_ack = 1'b0;
    m_cyc   = '1;
    m_stb   = '1;
    m_we    = '1;
    m_sel   = '1;
    m_adr   = '1;
    m_datw  = '1;
    wb_ack  = 1'b1;
    wb_datr = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, '0);
    check("rst_m_ack", m_ack, '0);
    check("rst_m_err", m_err, '0);
    check("rst_wb_cyc", {wb_cyc, wb_stb, wb_we}, '0);
    check("rst_wb_adr", wb_adr, '0);
    @(posedge clk);
    #1;
    m_cyc  = '0;
    m_stb  = '0;
    wb_ack = 1'b0;
    rst    = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, compare every output with the model, advance the model.
  task automatic cycle();
    logic [N-1:0] e_grant;
    logic         hit;
    logic         e_cyc, e_stb, e_we;
    logic [3:0]   e_sel;
    logic [31:0]  e_adr, e_datw;
    int           o;
    @(posedge clk);
    #1;
    m_cyc = drv_cyc;
    m_stb = drv_stb;
    m_we  = N'($urandom);
    m_sel = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      m_adr[32*i +: 32]  = $urandom;
      m_datw[32*i +: 32] = $urandom;
    end
    wb_ack  = drv_ack;
    wb_datr = $urandom;
    #3;
    o       = mdl_owner;
    e_grant = '0;
    hit     = 1'b0;
    e_cyc   = 1'b0;
    e_stb   = 1'b0;
    e_we    = 1'b0;
    e_sel   = '0;
    e_adr   = '0;
    e_datw  = '0;
    if (o >= 0) begin
      e_grant[o] = 1'b1;
      hit        = TO_EN && (mdl_stall == TO);
      e_cyc      = m_cyc[o] && !hit;
      e_stb      = m_stb[o] && !hit;
      e_we       = m_we[o];
      e_sel      = m_sel[4*o +: 4];
      e_adr      = m_adr[32*o +: 32];
      e_datw     = m_datw[32*o +: 32];
    end
    check("grant", grant, e_grant);
    check("m_ack", m_ack, drv_ack ? e_grant : '0);
    check("m_err", m_err, hit ? e_grant : '0);
    check("wb_cyc", wb_cyc, e_cyc);
    check("wb_stb", wb_stb, e_stb);
    check("wb_we", wb_we, e_we);
    check("wb_sel", wb_sel, e_sel);
    check("wb_adr", wb_adr, e_adr);
    check("wb_datw", wb_datw, e_datw);
    check("m_datr", m_datr, wb_datr);
    if (o < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (mdl_owner < 0 && drv_cyc[(mdl_last + k) % N]) mdl_owner = (mdl_last + k) % N;
      end
      mdl_stall = 0;
    end else if (!drv_cyc[o] || hit) begin
      mdl_last  = o;
      mdl_owner = -1;
      mdl_stall = 0;
    end else if (drv_ack) begin
      mdl_stall = 0;
    end else if (drv_stb[o]) begin
      mdl_stall++;
    end
  endtask

  int got_order[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int acked_owner;
  int acks;
  int ack_pct;
  logic [N-1:0] prev_grant;

  initial begin
    model_reset();
    apply_reset();

    // Single transfer: one-cycle grant latency, ack routed only to the owner.
    drv_cyc = 4'b0001; drv_stb = 4'b0001; drv_ack = 1'b0;
    cycle();
    check("c35_c0_grant", grant, 4'b0000);
    cycle();
    check("c35_c1_grant", grant, 4'b0001);
    check("c35_c1_cyc", wb_cyc, 1'b1);
    cycle();
    drv_ack = 1'b1;
    cycle();
    check("c35_c3_ack", m_ack, 4'b0001);
    drv_ack = 1'b0;
    cycle();
    check("c35_c4_ack", m_ack, 4'b0000);
    drv_cyc = '0; drv_stb = '0;
    cycle();
    cycle();

    // Four persistent requesters, one beat each: strict rotation from port 0.
    apply_reset();
    acked_owner = -1;
    prev_grant  = '0;
    drv_stb     = '1;
    drv_cyc     = '1;
    for (int n = 0; n < 15; n++) begin
      drv_ack = 1'b0;
      if (mdl_owner >= 0) begin
        if (acked_owner == mdl_owner) drv_cyc[mdl_owner] = 1'b0;
        else begin
          drv_ack     = 1'b1;
          acked_owner = mdl_owner;
        end
      end else begin
        drv_cyc = '1;
      end
      cycle();
      if (grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) got_order.push_back(i);
      end
      prev_grant = grant;
    end
    check("rr_count", got_order.size(), 5);
    for (int i = 0; i < 5 && i < got_order.size(); i++) check("rr_order", got_order[i], exp_order[i]);
    drv_cyc = '0; drv_stb = '0; drv_ack = 1'b0;
    cycle();
    cycle();

    // Burst ownership: port 2 keeps three beats while port 1 waits.
    acks    = 0;
    drv_cyc = 4'b0100; drv_stb = 4'b0100;
    cycle();
    drv_cyc = 4'b0110; drv_stb = 4'b0110;
    drv_ack = 1'b1; cycle(); acks += int'(m_ack[2]);
    drv_ack = 1'b0; cycle(); acks += int'(m_ack[2]);
    drv_ack = 1'b1; cycle(); acks += int'(m_ack[2]);
    drv_ack = 1'b1; cycle(); acks += int'(m_ack[2]);
    check("c37_hold_grant", grant, 4'b0100);
    check("c37_acks", acks, 3);
    drv_ack = 1'b0;
    drv_cyc = 4'b0010; drv_stb = 4'b0010;
    cycle();
    check("c37_drop_cyc", wb_cyc, 1'b0);
    cycle();
    check("c37_gap", grant, 4'b0000);
    cycle();
    check("c37_next", grant, 4'b0010);
    drv_cyc = '0; drv_stb = '0;
    cycle();
    cycle();

    // Abandoned cycle: late ack must be swallowed.
    drv_cyc = 4'b1000; drv_stb = 4'b1000;
    cycle();
    cycle();
    check("c38_grant", grant, 4'b1000);
    drv_cyc = '0; drv_stb = '0;
    cycle();
    drv_ack = 1'b1;
    cycle();
    check("c38_late_ack", m_ack, 4'b0000);
    check("c38_idle", grant, 4'b0000);
    drv_ack = 1'b0;
    cycle();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks port 1: error on the ninth busy cycle, then port 2 gets in.
    apply_reset();
    drv_cyc = 4'b0010; drv_stb = 4'b0010; drv_ack = 1'b0;
    cycle();
    drv_cyc = 4'b0110;
    for (int b = 1; b <= 9; b++) begin
      cycle();
      if (b == 8) check("to_err8", m_err, 4'b0000);
    end
    check("to_err9", m_err, 4'b0010);
    check("to_cyc9", wb_cyc, 1'b0);
    cycle();
    check("to_gap", grant, 4'b0000);
    cycle();
    check("to_next", grant, 4'b0100);
    drv_cyc = '0; drv_stb = '0;
    cycle();
    cycle();
`endif

    // Reset in the middle of an acked beat kills everything at once.
    drv_cyc = 4'b0100; drv_stb = 4'b0100; drv_ack = 1'b0;
    cycle();
    cycle();
    @(posedge clk);
    #1;
    wb_ack = 1'b1;
    #1;
    check("c40_pre_ack", m_ack, 4'b0100);
    rst = 1'b1;
    #1;
    check("c40_rst_grant", grant, 4'b0000);
    check("c40_rst_ack", m_ack, 4'b0000);
    check("c40_rst_cyc", wb_cyc, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    m_cyc = '0; m_stb = '0; wb_ack = 1'b0;
    rst   = 1'b0;
    drv_cyc = 4'b0011; drv_stb = 4'b0011; drv_ack = 1'b0;
    cycle();
    cycle();
    check("c40_port0_first", grant, 4'b0001);
    drv_cyc = '0; drv_stb = '0;
    cycle();
    cycle();

    // Random traffic with decreasing slave responsiveness.
    for (int ph = 0; ph < 3; ph++) begin
      ack_pct = (ph == 0) ? 50 : ((ph == 1) ? 15 : 0);
      for (int n = 0; n < 700; n++) begin
        for (int i = 0; i < N; i++) begin
          if (drv_cyc[i]) begin
            if ($urandom_range(99) < 12) drv_cyc[i] = 1'b0;
          end else if ($urandom_range(99) < 30) begin
            drv_cyc[i] = 1'b1;
          end
        end
        drv_stb = drv_cyc & N'($urandom);
        drv_ack = ($urandom_range(99) < ack_pct);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arb.md
WB_RR_ARB -- requirements
Module: wb_rr_arb

Interface
- REQ-001: Parameter NUM_PORTS, default 4: number of Wishbone master ports; legal range 2..16.
- REQ-002: Parameter TIMEOUT_CYCLES, default 255: stalled-strobe limit before an error is forced; legal range 1..65535.
- REQ-003: clk  in  1  single clock; all state changes on the rising edge.
- REQ-004: rst  in  1  reset, asynchronous, active-high.
- REQ-005: m_cyc  in  NUM_PORTS  per-master cycle request.
- REQ-006: m_stb  in  NUM_PORTS  per-master strobe.
- REQ-007: m_we  in  NUM_PORTS  per-master write enable.
- REQ-008: m_sel  in  4*NUM_PORTS  byte selects; port i occupies bits [4i+3:4i].
- REQ-009: m_adr  in  32*NUM_PORTS  byte addresses; port i occupies bits [32i+31:32i].
- REQ-010: m_datw  in  32*NUM_PORTS  write data, packed like m_adr.
- REQ-011: m_ack  out  NUM_PORTS  per-master acknowledge.
- REQ-012: m_err  out  NUM_PORTS  per-master timeout error pulse.
- REQ-013: m_datr  out  32  read data, broadcast to all masters.
- REQ-014: wb_cyc, wb_stb, wb_we  out  1 each  slave-side controls.
- REQ-015: wb_sel  out  4; wb_adr  out  32; wb_datw  out  32  slave-side payload.
- REQ-016: wb_ack  in  1; wb_datr  in  32  slave response.
- REQ-017: grant  out  NUM_PORTS  one-hot current owner; all zero when idle.

Function
- REQ-018: The arbiter SHALL have exactly two states: IDLE and BUSY.
- REQ-019: In IDLE, with any m_cyc[i] high, the arbiter SHALL register a grant to the first requester found scanning upward from (last+1) mod NUM_PORTS, and SHALL enter BUSY at the next edge.
- REQ-020: The arbiter SHALL forward all slave-side outputs combinationally from the granted port while in BUSY; in IDLE it SHALL drive every slave-side output to 0.
- REQ-021: Grant latency SHALL be exactly one cycle: a request first visible in cycle t drives wb_cyc in cycle t+1.
- REQ-022: m_ack[g] SHALL equal wb_ack AND BUSY AND grant[g]; every other m_ack bit SHALL be 0.
- REQ-023: m_datr SHALL equal wb_datr at all times.
- REQ-024: The grant SHALL persist across multiple strobe/ack beats while m_cyc[g] stays high, giving burst ownership.
- REQ-025: When m_cyc[g] falls in BUSY, wb_cyc SHALL fall in the same cycle, and the arbiter SHALL enter IDLE and set last=g at the next edge.
- REQ-026: One IDLE cycle SHALL separate consecutive tenures.
- REQ-027: Requests arriving while BUSY SHALL wait and never preempt the owner.
- REQ-028: A master that drops m_cyc before receiving its ack SHALL lose the grant, and any late wb_ack SHALL be discarded.

Reset
- REQ-029: While rst is high, the arbiter SHALL force state=IDLE, grant=0, last=NUM_PORTS-1, the timeout counter to 0, and m_ack, m_err and all slave-side outputs to 0, asynchronously.
- REQ-030: After reset, port 0 SHALL have first priority.
- REQ-031: Reset mid-tenure SHALL abort the tenure with no ack or err issued.

Configuration
- REQ-032: With macro WB_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL increment each cycle that BUSY, wb_stb=1 and wb_ack=0 hold, and SHALL clear on wb_ack or on leaving BUSY.
- REQ-033: With WB_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES, the arbiter SHALL pulse m_err[g] for one cycle, force wb_cyc and wb_stb to 0 in that cycle, enter IDLE, and set last=g.
- REQ-034: With WB_ARB_TIMEOUT_EN not defined, no counter SHALL be built, m_err SHALL be tied to 0, and ownership SHALL be unbounded.

Verification
- REQ-035: Reset release, then m_cyc=4'b0001 with m_stb=1 at cycle 0 -> grant=4'b0001 and wb_cyc=1 in cycle 1; wb_ack=1 in cycle 3 -> m_ack=4'b0001 in cycle 3 only.
- REQ-036: m_cyc=4'b1111 held, each master dropping cyc after one ack -> grant order 0,1,2,3,0 with exactly one idle cycle between tenures.
- REQ-037: Port 2 holds cyc for 3 beats (wb_ack on 3 separate cycles) while port 1 requests -> three m_ack[2] pulses, then port 1 granted 2 cycles after port 2 drops cyc.
- REQ-038: Port 3 drops cyc with no ack, then wb_ack=1 arrives one cycle later -> m_ack stays 0 and the arbiter returns to IDLE.
- REQ-039: With WB_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, port 1 strobes and the slave never acks -> m_err[1] pulses in the 9th BUSY cycle, wb_cyc=0 in that cycle, and the next requester is granted afterwards.
- REQ-040: rst asserted during a BUSY cycle with wb_ack=1 -> grant, m_ack and wb_cyc are 0 immediately; after release, port 0 wins a simultaneous 0/1 request.
